alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the ALU interface: decodes a RISC-V instruction plus register operands into
//  ALU_Operation / A / B and presents them to the ALU through a registered valid/ready stage
//  with a 2-entry skid buffer. Sits between register-file read and the ALU.
//  Supported set: ADD, SUB, ADDI, LUI, AUIPC.
// PARAMETERS
//  DATA_WIDTH   32   operand/result width. Only 32 is supported; the immediate rules assume it.
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   asynchronous, active-low reset
//  Instr_Valid_i    in   1   upstream has an instruction
//  Instr_Ready_o    out  1   stage can accept (registered, =!FULL)
//  Instruction_i    in   32  raw instruction word
//  PC_i             in   32  instruction address (AUIPC)
//  Rs1_Data_i       in   32  rs1 read data
//  Rs2_Data_i       in   32  rs2 read data
//  Issue_Valid_o    out  1   head entry valid toward ALU
//  Issue_Ready_i    in   1   ALU/next stage consumes head
//  ALU_Operation_o  out  4   0000 ADD, 0001 SUB, 0010 LUI, 1111 illegal/nop
//  A_o              out  32  ALU operand A
//  B_o              out  32  ALU operand B
//  Rd_o             out  5   destination register
//  Reg_Write_o      out  1   write-back enable
//  Illegal_o        out  1   head instruction undecodable
// BEHAVIOUR
//  - Reset (async assert, sync release): state EMPTY, Issue_Valid_o=0, Instr_Ready_o=1,
//    all payload outputs 0.
//  - Accept on Instr_Valid_i&&Instr_Ready_o; pop on Issue_Valid_o&&Issue_Ready_i.
//  - States: EMPTY (0 entries), ONE (1), FULL (2). Transitions:
//    EMPTY: accept->ONE. ONE: accept&!pop->FULL, pop&!accept->EMPTY, both->ONE (new entry
//    replaces head). FULL: pop->ONE (skid entry becomes head); no accept, since Instr_Ready_o=0.
//  - Latency: accepted instruction drives Issue_Valid_o the next cycle (1 cycle) if empty.
//    Back-to-back throughput is 1/cycle with Issue_Ready_i held high.
//  - Payload is stable while Issue_Valid_o=1 and Issue_Ready_i=0. Order is strictly FIFO.
//  - Decode (opcode[6:0], funct3, funct7) is done at accept time; decoded fields are stored:
//    0110011/000/0000000 ADD: A=rs1, B=rs2
//    0110011/000/0100000 SUB: A=rs1, B=rs2
//    0010011/000 ADDI: op ADD, A=rs1, B=sign-extended instr[31:20]
//    0110111 LUI: op LUI, A=0, B={instr[31:12],12'b0}
//    0010111 AUIPC: op ADD, A=PC_i, B={instr[31:12],12'b0}
//    anything else: op 1111, A=B=0, Reg_Write_o=0, Illegal_o=1
//  - Rd_o=instr[11:7]. Reg_Write_o=1 for legal ops except when rd==0 (forced 0).
//  - Arithmetic: no computation here beyond immediate formation; wrap-around belongs to the ALU.
//  - Simultaneous accept+pop in ONE: head replaced the same edge, no bubble.
//  - Reset mid-operation: both entries dropped immediately; no partial issue.
// CONFIGURATION
//  ALU_ISSUE_STATS_EN defined: adds ports Issued_Count_o[15:0] and Illegal_Count_o[15:0].
//    Issued_Count_o counts pops. Illegal_Count_o counts pops with Illegal_o=1.
//    Both counters reset to 0 and wrap 0xFFFF->0x0000.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 reset low, then release -> Issue_Valid_o=0, Instr_Ready_o=1, ALU_Operation_o=0000
//  2 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, Ready_i=1 -> next cycle op=0000, A=5, B=7,
//    Rd=3, Reg_Write=1
//  3 SUB (0x402081B3) then LUI x5,0x12345 (0x123452B7), Issue_Ready_i=0
//    -> FULL, Instr_Ready_o=0, SUB held; raise Ready_i -> SUB then op=0010, B=0x12345000
//  4 ADDI x1,x0,-1 (0xFFF00093) -> B=0xFFFFFFFF; AUIPC x0 with PC=0x400000
//    -> A=0x400000, Reg_Write=0
//  5 word 0xFFFFFFFF -> op=1111, Illegal_o=1, Reg_Write_o=0
//    (STATS_EN: Illegal_Count_o increments by 1 on pop)
//  6 assert reset while FULL -> Issue_Valid_o=0 immediately, Instr_Ready_o=1,
//    no stale issue after release

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Producer side of the ALU interface. Decodes a RISC-V instruction
//            (ADD, SUB, ADDI, LUI, AUIPC) plus register operands into an ALU
//            operation and A/B operands, and presents them to the ALU through
//            a registered valid/ready stage with a 2-entry skid buffer.
// Ports    : clk, reset (async, active-low)
//            Instr_Valid_i / Instr_Ready_o      upstream handshake
//            Instruction_i, PC_i, Rs1_Data_i, Rs2_Data_i   decode inputs
//            Issue_Valid_o / Issue_Ready_i      downstream handshake
//            ALU_Operation_o, A_o, B_o, Rd_o, Reg_Write_o, Illegal_o  head payload
//            Issued_Count_o, Illegal_Count_o    (only with ALU_ISSUE_STATS_EN)
// Config   : define ALU_ISSUE_STATS_EN to add the pop / illegal-pop counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Instr_Valid_i,
  output logic                  Instr_Ready_o,
  input  logic [31:0]           Instruction_i,
  input  logic [DATA_WIDTH-1:0] PC_i,
  input  logic [DATA_WIDTH-1:0] Rs1_Data_i,
  input  logic [DATA_WIDTH-1:0] Rs2_Data_i,
  output logic                  Issue_Valid_o,
  input  logic                  Issue_Ready_i,
  output logic [3:0]            ALU_Operation_o,
  output logic [DATA_WIDTH-1:0] A_o,
  output logic [DATA_WIDTH-1:0] B_o,
  output logic [4:0]            Rd_o,
  output logic                  Reg_Write_o,
  output logic                  Illegal_o
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]           Issued_Count_o,
  output logic [15:0]           Illegal_Count_o
`endif
);

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_LUI     = 4'b0010;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q,  head_d;
  entry_t skid_q,  skid_d;
  logic   ready_q, ready_d;
  entry_t dec_entry;

  logic accept;
  logic pop;

  assign accept = Instr_Valid_i && ready_q;
  assign pop    = (state_q != ST_EMPTY) && Issue_Ready_i;

  // ------------------------------------------------------------------------
  // Decode happens on the incoming word so only decoded fields are stored.
  // ------------------------------------------------------------------------
  always_comb begin
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    opcode    = Instruction_i[6:0];
    funct3    = Instruction_i[14:12];
    funct7    = Instruction_i[31:25];
    legal     = 1'b1;
    dec_entry = '0;
    dec_entry.rd = Instruction_i[11:7];

    if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == 7'b0000000) begin
      dec_entry.op = OP_ADD;
      dec_entry.a  = Rs1_Data_i;
      dec_entry.b  = Rs2_Data_i;
    end else if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == 7'b0100000) begin
      dec_entry.op = OP_SUB;
      dec_entry.a  = Rs1_Data_i;
      dec_entry.b  = Rs2_Data_i;
    end else if (opcode == OPC_OP_IMM && funct3 == 3'b000) begin
      dec_entry.op = OP_ADD;
      dec_entry.a  = Rs1_Data_i;
      dec_entry.b  = {{20{Instruction_i[31]}}, Instruction_i[31:20]};
    end else if (opcode == OPC_LUI) begin
      dec_entry.op = OP_LUI;
      dec_entry.a  = '0;
      dec_entry.b  = {Instruction_i[31:12], 12'b0};
    end else if (opcode == OPC_AUIPC) begin
      dec_entry.op = OP_ADD;
      dec_entry.a  = PC_i;
      dec_entry.b  = {Instruction_i[31:12], 12'b0};
    end else begin
      legal        = 1'b0;
      dec_entry.op = OP_ILLEGAL;
    end

    dec_entry.illegal   = !legal;
    // Writes to x0 are architecturally discarded, so suppress them here.
    dec_entry.reg_write = legal && (Instruction_i[11:7] != 5'd0);
  end

  // ------------------------------------------------------------------------
  // Skid-buffer occupancy control.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = dec_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          // Head leaves and the new word takes its place on the same edge.
          head_d  = dec_entry;
        end else if (accept) begin
          skid_d  = dec_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Upstream is stalled in this state, so only a pop can occur.
        if (pop) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Ready is registered: it reflects the occupancy we are about to enter.
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign Instr_Ready_o   = ready_q;
  assign Issue_Valid_o   = (state_q != ST_EMPTY);
  assign ALU_Operation_o = head_q.op;
  assign A_o             = head_q.a;
  assign B_o             = head_q.b;
  assign Rd_o            = head_q.rd;
  assign Reg_Write_o     = head_q.reg_write;
  assign Illegal_o       = head_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
  // ------------------------------------------------------------------------
  // Issue statistics; both counters wrap naturally at 16 bits.
  // ------------------------------------------------------------------------
  logic [15:0] issued_cnt_q,  issued_cnt_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  always_comb begin
    issued_cnt_d  = issued_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (pop) begin
      issued_cnt_d = issued_cnt_q + 16'd1;
      if (head_q.illegal) begin
        illegal_cnt_d = illegal_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      issued_cnt_q  <= issued_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign Issued_Count_o  = issued_cnt_q;
  assign Illegal_Count_o = illegal_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Directed self-checking bench for alu_issue_stage. Inputs change
//            and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        Instr_Valid_i;
  logic        Instr_Ready_o;
  logic [31:0] Instruction_i;
  logic [31:0] PC_i;
  logic [31:0] Rs1_Data_i;
  logic [31:0] Rs2_Data_i;
  logic        Issue_Valid_o;
  logic        Issue_Ready_i;
  logic [3:0]  ALU_Operation_o;
  logic [31:0] A_o;
  logic [31:0] B_o;
  logic [4:0]  Rd_o;
  logic        Reg_Write_o;
  logic        Illegal_o;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] Issued_Count_o;
  logic [15:0] Illegal_Count_o;
`endif

  int n_compared;
  int n_mismatched;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .Instr_Valid_i   (Instr_Valid_i),
    .Instr_Ready_o   (Instr_Ready_o),
    .Instruction_i   (Instruction_i),
    .PC_i            (PC_i),
    .Rs1_Data_i      (Rs1_Data_i),
    .Rs2_Data_i      (Rs2_Data_i),
    .Issue_Valid_o   (Issue_Valid_o),
    .Issue_Ready_i   (Issue_Ready_i),
    .ALU_Operation_o (ALU_Operation_o),
    .A_o             (A_o),
    .B_o             (B_o),
    .Rd_o            (Rd_o),
    .Reg_Write_o     (Reg_Write_o),
    .Illegal_o       (Illegal_o)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .Issued_Count_o  (Issued_Count_o),
    .Illegal_Count_o (Illegal_Count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic next_neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc);
    Instr_Valid_i = vld;
    Instruction_i = instr;
    Rs1_Data_i    = rs1;
    Rs2_Data_i    = rs2;
    PC_i          = pc;
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b0;
    Issue_Ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

    // 1: reset state
    repeat (3) next_neg();
    check_val("rst_valid", {31'b0, Issue_Valid_o}, 32'd0);
    check_val("rst_ready", {31'b0, Instr_Ready_o}, 32'd1);
    check_val("rst_op",    {28'b0, ALU_Operation_o}, 32'd0);
    check_val("rst_a",     A_o, 32'd0);
    check_val("rst_b",     B_o, 32'd0);
    reset = 1'b1;
    next_neg();
    check_val("rel_valid", {31'b0, Issue_Valid_o}, 32'd0);
    check_val("rel_ready", {31'b0, Instr_Ready_o}, 32'd1);

    // 2: ADD x3,x1,x2 with 1-cycle latency
    Issue_Ready_i = 1'b1;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 32'h0);
    next_neg();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_val("add_valid", {31'b0, Issue_Valid_o}, 32'd1);
    check_val("add_op",    {28'b0, ALU_Operation_o}, 32'h0);
    check_val("add_a",     A_o, 32'd5);
    check_val("add_b",     B_o, 32'd7);
    check_val("add_rd",    {27'b0, Rd_o}, 32'd3);
    check_val("add_rw",    {31'b0, Reg_Write_o}, 32'd1);
    check_val("add_ill",   {31'b0, Illegal_o}, 32'd0);
    next_neg();
    check_val("add_drain", {31'b0, Issue_Valid_o}, 32'd0);

    // 3: SUB then LUI with downstream stalled -> FULL, SUB held
    Issue_Ready_i = 1'b0;
    drive(1'b1, 32'h402081B3, 32'd10, 32'd3, 32'h0);
    next_neg();
    check_val("one_ready", {31'b0, Instr_Ready_o}, 32'd1);
    drive(1'b1, 32'h123452B7, 32'hDEAD, 32'hBEEF, 32'h0);
    next_neg();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_val("full_ready", {31'b0, Instr_Ready_o}, 32'd0);
    check_val("full_valid", {31'b0, Issue_Valid_o}, 32'd1);
    check_val("sub_op",     {28'b0, ALU_Operation_o}, 32'h1);
    check_val("sub_a",      A_o, 32'd10);
    check_val("sub_b",      B_o, 32'd3);
    // Upstream keeps offering while full; it must be ignored.
    drive(1'b1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    next_neg();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_val("hold_op",    {28'b0, ALU_Operation_o}, 32'h1);
    check_val("hold_a",     A_o, 32'd10);
    check_val("hold_ready", {31'b0, Instr_Ready_o}, 32'd0);
    Issue_Ready_i = 1'b1;
    next_neg();
    check_val("lui_op",    {28'b0, ALU_Operation_o}, 32'h2);
    check_val("lui_a",     A_o, 32'h0);
    check_val("lui_b",     B_o, 32'h12345000);
    check_val("lui_rd",    {27'b0, Rd_o}, 32'd5);
    check_val("lui_rw",    {31'b0, Reg_Write_o}, 32'd1);
    check_val("lui_ready", {31'b0, Instr_Ready_o}, 32'd1);
    next_neg();
    check_val("lui_drain", {31'b0, Issue_Valid_o}, 32'd0);

    // 4/5: back-to-back ADDI, AUIPC x0, illegal word with ready held high
    drive(1'b1, 32'hFFF00093, 32'h11, 32'h0, 32'h0);
    next_neg();
    drive(1'b1, 32'h00001017, 32'h0, 32'h0, 32'h00400000);
    check_val("addi_op",  {28'b0, ALU_Operation_o}, 32'h0);
    check_val("addi_a",   A_o, 32'h11);
    check_val("addi_b",   B_o, 32'hFFFFFFFF);
    check_val("addi_rd",  {27'b0, Rd_o}, 32'd1);
    check_val("addi_rw",  {31'b0, Reg_Write_o}, 32'd1);
    next_neg();
    drive(1'b1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    check_val("auipc_valid", {31'b0, Issue_Valid_o}, 32'd1);
    check_val("auipc_op",    {28'b0, ALU_Operation_o}, 32'h0);
    check_val("auipc_a",     A_o, 32'h00400000);
    check_val("auipc_b",     B_o, 32'h00001000);
    check_val("auipc_rw",    {31'b0, Reg_Write_o}, 32'd0);
    check_val("auipc_ill",   {31'b0, Illegal_o}, 32'd0);
    next_neg();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_val("ill_op",  {28'b0, ALU_Operation_o}, 32'hF);
    check_val("ill_ill", {31'b0, Illegal_o}, 32'd1);
    check_val("ill_rw",  {31'b0, Reg_Write_o}, 32'd0);
    check_val("ill_a",   A_o, 32'h0);
    check_val("ill_b",   B_o, 32'h0);
    next_neg();
    check_val("ill_drain", {31'b0, Issue_Valid_o}, 32'd0);
`ifdef ALU_ISSUE_STATS_EN
    check_val("cnt_issued",  {16'b0, Issued_Count_o}, 32'd6);
    check_val("cnt_illegal", {16'b0, Illegal_Count_o}, 32'd1);
`endif

    // 6: asynchronous reset while FULL
    Issue_Ready_i = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 32'h0);
    next_neg();
    drive(1'b1, 32'h402081B3, 32'd3, 32'd4, 32'h0);
    next_neg();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_val("pre_rst_ready", {31'b0, Instr_Ready_o}, 32'd0);
    check_val("pre_rst_valid", {31'b0, Issue_Valid_o}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("arst_valid", {31'b0, Issue_Valid_o}, 32'd0);
    check_val("arst_ready", {31'b0, Instr_Ready_o}, 32'd1);
    check_val("arst_op",    {28'b0, ALU_Operation_o}, 32'd0);
    next_neg();
    reset = 1'b1;
    Issue_Ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_neg();
      check_val("post_rst_valid", {31'b0, Issue_Valid_o}, 32'd0);
    end
`ifdef ALU_ISSUE_STATS_EN
    check_val("post_rst_cnt", {16'b0, Issued_Count_o}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
